reg_file_gen: RTL

- Parametrised, second-generation register file for the 8-bit core datapath.
- Provides 2 combinational read ports and 2 prioritised clocked write ports:
  - Port A is the primary ALU/load writeback.
  - Port B is the secondary writeback, used for the R0 result and first-operand-register writes.
- Adds asynchronous reset and a sequenced clear engine with a busy/done handshake.
- Sits between decode (read addresses) and writeback (write ports) in the core.

---
 rtl/reg_file_pkg.sv | 24 ++
 rtl/reg_clr_seq.sv | 72 +++++++
 rtl/reg_file_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared types and constants for the reg_file_gen register
//                file and its clear sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  // Default datapath geometry: 8-bit words, 8 entries
  localparam int DW_DEF  = 8;
  localparam int AW_DEF  = 3;

  // Address that decode drives onto wb_addr for R0 result writes
  localparam int R0_ADDR = 0;

  // Clear engine states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_clr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : reg_clr_seq
//  Description : Sequenced clear engine for reg_file_gen. Walks every entry
//                once (one per cycle), reports busy/done, gates the write
//                ports while running and flags writes it had to discard.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_clr_seq
  import reg_file_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  input  logic          wr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          wr_drop,
  output logic          wr_gate,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  // State encodings kept as plain vectors for legacy tool flows
  localparam logic [0:0]    c_st_idle  = IDLE;
  localparam logic [0:0]    c_st_clear = CLEAR;
  localparam logic [AW-1:0] c_last     = '1;

  logic [0:0]    r_state;
  logic [AW-1:0] r_cnt;
  logic          r_done;
  logic          r_drop;
  logic          w_clearing;
  logic          w_last;

  assign w_clearing = (r_state == c_st_clear);
  assign w_last     = (r_cnt == c_last);

  // FSM, entry counter and the registered done / drop indications
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_done <= w_clearing && w_last;
      r_drop <= w_clearing && wr_req;
      if (w_clearing) begin
        // counter wraps naturally back to 0 after the last entry
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_state <= c_st_idle;
        end
      end else if (clr_req) begin
        r_state <= c_st_clear;
        r_cnt   <= '0;
      end
    end
  end

  assign clr_busy = w_clearing;
  assign clr_done = r_done;
  assign wr_drop  = r_drop;
  assign wr_gate  = ~w_clearing;
  assign clr_we   = w_clearing;
  assign clr_addr = r_cnt;

endmodule : reg_clr_seq
`default_nettype wire

// File: rtl/reg_file_gen.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_gen
//  Description : Parametrised register file, 2 combinational read ports and
//                2 prioritised clocked write ports (A beats B on collision),
//                asynchronous reset and a sequenced clear engine.
//                Optional macro REG_FILE_BYPASS_EN: read ports forward
//                same-cycle accepted write data (A before B).
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_gen
  import reg_file_pkg::*;
#(
  parameter int             DW      = DW_DEF,
  parameter int             AW      = AW_DEF,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wa_en,
  input  logic [AW-1:0] wa_addr,
  input  logic [DW-1:0] wa_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          wr_drop
);

  localparam int DEPTH = 2 ** AW;

  logic          w_wr_gate;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  logic [DW-1:0] w_core [DEPTH];

  reg_clr_seq #(
    .AW (AW)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .wr_req   (wa_en | wb_en),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop),
    .wr_gate  (w_wr_gate),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // One storage word per entry with its own write decode
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DW-1:0] r_word;
    logic          w_hit_a;
    logic          w_hit_b;
    logic          w_hit_clr;

    assign w_hit_a   = w_wr_gate && wa_en && (wa_addr == AW'(gi));
    assign w_hit_b   = w_wr_gate && wb_en && (wb_addr == AW'(gi));
    assign w_hit_clr = w_clr_we && (w_clr_addr == AW'(gi));

    // Clear beats writes (writes are gated off while clearing anyway); A beats B
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word <= RST_VAL;
      end else if (w_hit_clr) begin
        r_word <= RST_VAL;
      end else if (w_hit_a) begin
        r_word <= wa_data;
      end else if (w_hit_b) begin
        r_word <= wb_data;
      end
    end

    assign w_core[gi] = r_word;
  end

`ifdef REG_FILE_BYPASS_EN
  // Read muxes with same-cycle forwarding; A is checked last so it wins
  always_comb begin
    rd_data_a = w_core[rd_addr_a];
    rd_data_b = w_core[rd_addr_b];
    if (w_wr_gate && wb_en && (wb_addr == rd_addr_a)) rd_data_a = wb_data;
    if (w_wr_gate && wa_en && (wa_addr == rd_addr_a)) rd_data_a = wa_data;
    if (w_wr_gate && wb_en && (wb_addr == rd_addr_b)) rd_data_b = wb_data;
    if (w_wr_gate && wa_en && (wa_addr == rd_addr_b)) rd_data_b = wa_data;
  end
`else
  // Plain array reads: new write data appears the cycle after the edge
  assign rd_data_a = w_core[rd_addr_a];
  assign rd_data_b = w_core[rd_addr_b];
`endif

endmodule : reg_file_gen
`default_nettype wire
